mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
Upstream controller for the 4-to-1 multiplexer stage. It drives the mux select lines S1/S0 through channels A, B, C and D in turn. For each channel it waits a programmable settle time, then samples the mux output Y. It packs the four samples into a 4-bit frame and hands the frame downstream over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, cycles each channel is held selected before Y is sampled; legal range 1..255
CNT_W, 8, width of the settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request one scan; accepted only in IDLE
cont  input  1  continuous mode; sampled at frame handshake
Y  input  1  output of the 4-to-1 mux
S0  output  1  mux select LSB (sel[0])
S1  output  1  mux select MSB (sel[1])
busy  output  1  high in SETTLE or VALID
frame  output  4  frame[0]=A (S1S0=00), frame[1]=B (01), frame[2]=C (10), frame[3]=D (11)
frame_valid  output  1  frame is stable and offered downstream
frame_ready  input  1  downstream accepts the frame
frame_par  output  1  parity of frame; see Optional Feature

Behaviour:
- Reset (async, immediate, also mid-scan):
  - state=IDLE, sel=00, cnt=0
  - S0=S1=0, frame=0000, frame_valid=0, busy=0, frame_par=0
- States: IDLE, SETTLE, VALID.
- IDLE:
  - S1S0=00.
  - start=1 at an edge: next state SETTLE, sel=00, cnt=0.
- SETTLE, at each edge:
  - If cnt != SETTLE_CYCLES-1: cnt++.
  - If cnt == SETTLE_CYCLES-1: frame[sel] <= Y and cnt <= 0.
    - If sel==3: state <= VALID, frame_valid <= 1, sel <= 00.
    - Otherwise: sel <= sel+1.
- Timing: each channel is driven for exactly SETTLE_CYCLES cycles. frame_valid rises 4*SETTLE_CYCLES edges after the start-accept edge.
- Frame bits of channels not yet sampled keep their previous-scan value until overwritten. The frame register is updated only in SETTLE.
- VALID:
  - frame and frame_valid are held stable while frame_ready=0; no timeout.
  - frame_valid=1 and frame_ready=1 at an edge completes the handshake.
    - cont=1: go to SETTLE (sel=00, cnt=0), frame_valid <= 0. No idle cycle is inserted.
    - cont=0: go to IDLE, frame_valid <= 0.
- start is ignored outside IDLE. No queueing, no error.
- frame_ready is ignored while frame_valid=0.
- cont is ignored except at the handshake edge.
- S0/S1 are registered: they are a direct decode of sel, with no combinational path from inputs.
- busy = (state != IDLE).

Optional Feature:
Macro SCAN_PARITY_EN.
- Defined: frame_par is registered. It is updated on the edge that enters VALID, to the XOR of the complete new frame, and held with frame.
- Not defined: frame_par is tied to 0. The port remains, so the interface is identical in both builds.

Test Plan:
1. Single scan, SETTLE_CYCLES=2:
   - Stimulus: Y driven as mux of A=1, B=0, C=1, D=0; start pulsed; frame_ready=1.
   - Response: S1S0 steps 00,01,10,11, two cycles each. frame_valid is high 8 edges after start, with frame=4'b0101. Next cycle frame_valid=0, busy=0.
2. Backpressure:
   - Stimulus: same scan with frame_ready=0 for 5 cycles after frame_valid.
   - Response: frame=0101 and frame_valid=1 hold for all 5 cycles. Handshake completes on the cycle frame_ready rises.
3. Continuous mode:
   - Stimulus: cont=1, frame_ready=1; second scan with D=1, all others 0.
   - Response: S1S0=00 on the cycle after the first handshake. Second frame_valid arrives 8 edges after the first handshake, with frame=4'b1000.
4. Ignored start:
   - Stimulus: pulse start during SETTLE at channel 2.
   - Response: sequence is unchanged and only one frame is produced.
5. Async reset mid-scan:
   - Stimulus: assert rst between edges while S1S0=10.
   - Response: S0=S1=0, busy=0, frame=0000 immediately, without waiting for a clock edge. After release, a new start yields a full 4-channel scan.
6. Parity (SCAN_PARITY_EN defined):
   - Stimulus: frames 0101 and 0111.
   - Response: frame_par=0 and 1 respectively, asserted together with frame_valid. With the macro undefined, frame_par=0 always.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// Bus between the mux scan sequencer and its surroundings: mux select/sample
// lines plus the downstream frame valid/ready handshake.
interface mux_scan_sequencer_if;
    logic       start;
    logic       cont;
    logic       Y;
    logic       S0;
    logic       S1;
    logic       busy;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       frame_par;

    // Handshake: a frame transfers on a rising edge where frame_valid and
    // frame_ready are both high; frame/frame_par are stable while frame_valid
    // is high and frame_ready is low, and frame_ready is ignored otherwise.
    modport master (
        input  start, cont, Y, frame_ready,
        output S0, S1, busy, frame, frame_valid, frame_par
    );

    modport slave (
        output start, cont, Y, frame_ready,
        input  S0, S1, busy, frame, frame_valid, frame_par
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4-to-1 mux through channels A..D, samples Y after a settle time and
// offers the packed 4-bit frame downstream. Define SCAN_PARITY_EN for frame_par.
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mux_scan_sequencer_if.master    bus,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       frame_q, frame_d;
    logic             valid_q, valid_d;
    logic [1:0]       mux_sel_q;
    logic             busy_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETTLE;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    frame_d[sel_q] = bus.Y;
                    cnt_d          = '0;
                    if (sel_q == 2'd3) begin
                        state_d = VALID;
                        valid_d = 1'b1;
                        sel_d   = 2'd0;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VALID: begin
                // frame_valid is high exactly while in VALID, so this is the handshake.
                if (bus.frame_ready) begin
                    valid_d = 1'b0;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = bus.cont ? SETTLE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'd0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

`ifdef SCAN_PARITY_EN
    logic par_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            cnt_q     <= '0;
            frame_q   <= 4'd0;
            valid_q   <= 1'b0;
            mux_sel_q <= 2'd0;
            busy_q    <= 1'b0;
`ifdef SCAN_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            // Select lines are a registered copy of the next sel, so they never glitch on inputs.
            mux_sel_q <= sel_d;
            busy_q    <= (state_d != IDLE);
`ifdef SCAN_PARITY_EN
            if (state_q == SETTLE && state_d == VALID) begin
                par_q <= ^frame_d;
            end
`endif
        end
    end

    assign bus.S0          = mux_sel_q[0];
    assign bus.S1          = mux_sel_q[1];
    assign bus.busy        = busy_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = valid_q;
`ifdef SCAN_PARITY_EN
    assign bus.frame_par   = par_q;
`else
    assign bus.frame_par   = 1'b0;
`endif
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: table of scans plus hand-written
// continuous-mode, ignored-start and async-reset sequences.
module tb_mux_scan_sequencer;

    localparam int S = 2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [3:0] chan;
    logic [3:0] prev_frame;
    int         n_checks;
    int         n_fail;

    mux_scan_sequencer_if bus ();

    mux_scan_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Behavioural 4-to-1 mux: channel index is {S1,S0}.
    assign bus.Y = chan[{bus.S1, bus.S0}];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] chan;
        int         ready_delay;
        logic [3:0] exp_frame;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic par_expect(input logic p);
`ifdef SCAN_PARITY_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    // Runs from the cycle after the start-accept (or continuous handshake) edge
    // through the handshake edge. poke_k pulses start at that cycle index.
    task automatic scan_body(input logic [3:0] exp_frame, input logic exp_par,
                             input int ready_delay, input logic cont_v, input int poke_k);
        logic [3:0] partial;
        for (int k = 0; k < 4 * S; k++) begin
            for (int j = 0; j < 4; j++)
                partial[j] = ((j + 1) * S <= k) ? exp_frame[j] : prev_frame[j];
            if (k == poke_k) bus.start = 1'b1;
            check("sel", 32'({bus.S1, bus.S0}), 32'(k / S));
            check("busy_scan", 32'(bus.busy), 32'd1);
            check("valid_low", 32'(bus.frame_valid), 32'd0);
            check("frame_partial", 32'(bus.frame), 32'(partial));
            tick();
            bus.start = 1'b0;
        end
        check("valid_high", 32'(bus.frame_valid), 32'd1);
        check("frame", 32'(bus.frame), 32'(exp_frame));
        check("frame_par", 32'(bus.frame_par), 32'(par_expect(exp_par)));
        check("sel_valid", 32'({bus.S1, bus.S0}), 32'd0);
        check("state_valid", 32'(dbg_state), 32'd2);
        for (int d = 0; d < ready_delay; d++) begin
            tick();
            check("hold_valid", 32'(bus.frame_valid), 32'd1);
            check("hold_frame", 32'(bus.frame), 32'(exp_frame));
        end
        bus.frame_ready = 1'b1;
        bus.cont        = cont_v;
        tick();
        bus.frame_ready = 1'b0;
        bus.cont        = 1'b0;
        check("valid_drop", 32'(bus.frame_valid), 32'd0);
        check("busy_after", 32'(bus.busy), 32'(cont_v));
        check("sel_after", 32'({bus.S1, bus.S0}), 32'd0);
        check("frame_kept", 32'(bus.frame), 32'(exp_frame));
        prev_frame = exp_frame;
    endtask

    task automatic start_scan(input logic [3:0] c);
        chan      = c;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        n_checks        = 0;
        n_fail          = 0;
        prev_frame      = 4'd0;
        chan            = 4'd0;
        bus.start       = 1'b0;
        bus.cont        = 1'b0;
        bus.frame_ready = 1'b0;
        rst             = 1'b1;

        vecs[0] = '{chan: 4'b0101, ready_delay: 0, exp_frame: 4'b0101, exp_par: 1'b0};
        vecs[1] = '{chan: 4'b0101, ready_delay: 5, exp_frame: 4'b0101, exp_par: 1'b0};
        vecs[2] = '{chan: 4'b0111, ready_delay: 1, exp_frame: 4'b0111, exp_par: 1'b1};
        vecs[3] = '{chan: 4'b1000, ready_delay: 2, exp_frame: 4'b1000, exp_par: 1'b1};
        vecs[4] = '{chan: 4'b1111, ready_delay: 0, exp_frame: 4'b1111, exp_par: 1'b0};
        vecs[5] = '{chan: 4'b0000, ready_delay: 3, exp_frame: 4'b0000, exp_par: 1'b0};

        tick();
        tick();
        check("rst_sel", 32'({bus.S1, bus.S0}), 32'd0);
        check("rst_frame", 32'(bus.frame), 32'd0);
        check("rst_valid", 32'(bus.frame_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_par", 32'(bus.frame_par), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;

        // frame_ready in IDLE has no effect
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        tick();
        check("idle_ready_valid", 32'(bus.frame_valid), 32'd0);
        check("idle_ready_busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 6; i++) begin
            start_scan(vecs[i].chan);
            scan_body(vecs[i].exp_frame, vecs[i].exp_par, vecs[i].ready_delay, 1'b0, -1);
            tick();
            check("idle_after_busy", 32'(bus.busy), 32'd0);
        end

        // Continuous mode: second scan follows the handshake with no idle cycle
        start_scan(4'b0101);
        scan_body(4'b0101, 1'b0, 0, 1'b1, -1);
        chan = 4'b1000;
        scan_body(4'b1000, 1'b1, 0, 1'b0, -1);
        tick();
        check("cont_end_busy", 32'(bus.busy), 32'd0);

        // start during channel C is ignored; cont high mid-scan is ignored too
        bus.cont = 1'b1;
        start_scan(4'b0011);
        scan_body(4'b0011, 1'b0, 0, 1'b0, 2 * S);
        for (int c = 0; c < 10; c++) begin
            check("one_frame_valid", 32'(bus.frame_valid), 32'd0);
            check("one_frame_busy", 32'(bus.busy), 32'd0);
            tick();
        end

        // Asynchronous reset while S1S0=10
        start_scan(4'b0111);
        for (int k = 0; k < 2 * S; k++) tick();
        check("pre_rst_sel", 32'({bus.S1, bus.S0}), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_sel", 32'({bus.S1, bus.S0}), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        check("async_frame", 32'(bus.frame), 32'd0);
        check("async_valid", 32'(bus.frame_valid), 32'd0);
        tick();
        rst = 1'b0;
        prev_frame = 4'd0;
        tick();
        check("post_rst_state", 32'(dbg_state), 32'd0);
        start_scan(4'b1010);
        scan_body(4'b1010, 1'b0, 1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
